// File: rtl/rf_pkg.sv
// Register-file geometry shared by the writeback arbiter, its interface and its bench.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback requester bundle: flat valid/ready/addr/data vectors, one slice per requester.
interface rf_writeback_arbiter_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;

  modport master (output req_valid_i, req_addr_i, req_data_i, input req_ready_o);
  modport slave  (input req_valid_i, req_addr_i, req_data_i, output req_ready_o);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr_q and wraps; ptr moves past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;

  // Walk the search order backwards so the candidate closest to ptr_q overwrites the rest.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        ptr_d      = (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources and tracks
// pending destinations so decode can stall on RAW hazards.
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rf_writeback_arbiter_if.slave wb,
  input  logic                  issue_valid_i,
  input  logic [ADDR_W-1:0]     issue_addr_i,
  input  logic [ADDR_W-1:0]     rd_aa_i,
  input  logic [ADDR_W-1:0]     rd_ab_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic [ADDR_W-1:0]     rf_aw_o,
  output logic                  rf_wren_o,
  output logic [DATA_W-1:0]     rf_wrdata_o
);
  logic [NUM_REQ-1:0]  gnt;
  logic [NUM_REQ-1:0]  ready;
  logic                xfer;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [DATA_W-1:0]   xfer_data;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   aw_q, aw_d;
  logic [DATA_W-1:0]   wrdata_q, wrdata_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (wb.req_valid_i),
    .gnt_o (gnt)
  );

  // No handshake completes while reset is asserted.
  assign ready          = gnt & {NUM_REQ{~rst_i}};
  assign wb.req_ready_o = ready;

  always_comb begin
    xfer      = 1'b0;
    xfer_addr = '0;
    xfer_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        xfer      = 1'b1;
        xfer_addr = wb.req_addr_i[i*ADDR_W +: ADDR_W];
        xfer_data = wb.req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // x0 writes are acknowledged but never reach the register file.
  always_comb begin
    wren_d   = xfer && (xfer_addr != ZERO_REG);
    aw_d     = xfer ? xfer_addr : aw_q;
    wrdata_d = xfer ? xfer_data : wrdata_q;
  end

  // Clear first, then set: a same-edge issue belongs to a younger producer.
  always_comb begin
    sb_d = sb_q;
    if (xfer) sb_d[xfer_addr] = 1'b0;
    if (issue_valid_i && issue_addr_i != ZERO_REG) sb_d[issue_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wren_q   <= 1'b0;
      aw_q     <= '0;
      wrdata_q <= '0;
      sb_q     <= '0;
    end else begin
      wren_q   <= wren_d;
      aw_q     <= aw_d;
      wrdata_q <= wrdata_d;
      sb_q     <= sb_d;
    end
  end

  assign rf_wren_o   = wren_q;
  assign rf_aw_o     = aw_q;
  assign rf_wrdata_o = wrdata_q;

  // The in-flight term covers the cycle between the output register and the RF commit.
  assign busy_a_o = (rd_aa_i != ZERO_REG) && (sb_q[rd_aa_i] || (wren_q && aw_q == rd_aa_i));
  assign busy_b_o = (rd_ab_i != ZERO_REG) && (sb_q[rd_ab_i] || (wren_q && aw_q == rd_ab_i));

  // Re-issuing a busy destination is illegal unless its old producer retires at this edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && issue_valid_i && issue_addr_i != ZERO_REG)
      assert (!sb_q[issue_addr_i] || (xfer && xfer_addr == issue_addr_i));
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized bench for rf_writeback_arbiter against a queue/array reference model.
module tb_rf_writeback_arbiter;
  import rf_pkg::*;
  localparam int N  = 3;
  localparam int AW = REG_ADDR_W;
  localparam int DW = REG_DATA_W;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          issue_valid_i;
  logic [AW-1:0] issue_addr_i, rd_aa_i, rd_ab_i;
  logic          busy_a_o, busy_b_o, rf_wren_o;
  logic [AW-1:0] rf_aw_o;
  logic [DW-1:0] rf_wrdata_o;

  rf_writeback_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) wb ();

  rf_writeback_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wb            (wb),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .rd_aa_i       (rd_aa_i),
    .rd_ab_i       (rd_ab_i),
    .busy_a_o      (busy_a_o),
    .busy_b_o      (busy_b_o),
    .rf_aw_o       (rf_aw_o),
    .rf_wren_o     (rf_wren_o),
    .rf_wrdata_o   (rf_wrdata_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Stimulus state: requesters hold v/a/d until granted.
  bit   [N-1:0]  v;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  bit            iv, r;
  logic [AW-1:0] ia, ra, rb;
  int            last_g;

  // Reference model: next-search pointer, last accepted write, pending set.
  int                  m_ptr;
  bit                  m_wren;
  logic [AW-1:0]       m_aw;
  logic [DW-1:0]       m_data;
  bit   [NUM_REGS-1:0] m_sb;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_busy(input logic [AW-1:0] x);
    return 32'((x != 0) && (m_sb[x] || (m_wren && m_aw == x)));
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wren = 1'b0; m_aw = '0; m_data = '0; m_sb = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      wb.req_addr_i[i*AW +: AW] = a[i];
      wb.req_data_i[i*DW +: DW] = d[i];
    end
    wb.req_valid_i = v;
    rst_i          = r;
    issue_valid_i  = iv;
    issue_addr_i   = ia;
    rd_aa_i        = ra;
    rd_ab_i        = rb;
  endtask

  // One cycle: drive, compare outputs with the model, clock, advance the model.
  task automatic step();
    int         g;
    logic [N-1:0] er;
    drive();
    #2;
    g = -1;
    if (!r)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready",  32'(wb.req_ready_o), 32'(er));
    chk("wren",   32'(rf_wren_o), 32'(m_wren));
    chk("aw",     32'(rf_aw_o), 32'(m_aw));
    chk("wrdata", rf_wrdata_o, m_data);
    chk("busy_a", 32'(busy_a_o), exp_busy(ra));
    chk("busy_b", 32'(busy_b_o), exp_busy(rb));
    @(posedge clk_i);
    last_g = g;
    if (r) model_reset();
    else begin
      if (g >= 0) begin
        m_ptr      = (g + 1) % N;
        m_wren     = (a[g] != 0);
        m_aw       = a[g];
        m_data     = d[g];
        m_sb[a[g]] = 1'b0;
        v[g]       = 1'b0;
      end else m_wren = 1'b0;
      if (iv && ia != 0) m_sb[ia] = 1'b1;
    end
    #1;
  endtask

  initial begin
    // Reset with every input active.
    v = '1; iv = 1'b1; ia = 5; ra = 5; rb = 5; r = 1'b1;
    for (int i = 0; i < N; i++) begin a[i] = 5; d[i] = $urandom; end
    model_reset();
    drive();
    @(posedge clk_i); #1;
    step(); step();
    r = 1'b0; iv = 1'b0;

    // Contention between req0 and req1 from pointer 0.
    v = 3'b011;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_order", 32'(last_g), 32'(k % 2));
      v[last_g] = 1'b1;
      d[last_g] = $urandom;
      a[last_g] = AW'(k + 10);
    end
    v = '0;

    // Single write to x5.
    iv = 1'b1; ia = 5; step();
    iv = 1'b0; v[0] = 1'b1; a[0] = 5; d[0] = 32'hDEADBEEF; ra = 5;
    step();
    chk("single_wren", 32'(rf_wren_o), 32'd1);
    chk("single_aw",   32'(rf_aw_o), 32'd5);
    chk("single_data", rf_wrdata_o, 32'hDEADBEEF);
    chk("busy5_inflight", 32'(busy_a_o), 32'd1);
    step();
    chk("busy5_after", 32'(busy_a_o), 32'd0);

    // Write to x0 is acked but not written.
    v[1] = 1'b1; a[1] = 0; d[1] = 32'h1234; ra = 0;
    step();
    chk("x0_grant", 32'(last_g), 32'd1);
    chk("x0_wren",  32'(rf_wren_o), 32'd0);
    chk("x0_busy",  32'(busy_a_o), 32'd0);

    // Set/clear collision on x7.
    iv = 1'b1; ia = 7; step();
    v[1] = 1'b1; a[1] = 7; d[1] = $urandom; ra = 7;
    step();
    iv = 1'b0; step();
    chk("sb7_kept", 32'(busy_a_o), 32'd1);

    // Reset right after a transfer.
    v[0] = 1'b1; a[0] = 9; d[0] = $urandom; iv = 1'b1; ia = 12;
    step();
    iv = 1'b0; r = 1'b1; step();
    r = 1'b0; ra = 7; rb = 12; drive(); #1;
    chk("rst_wren",  32'(rf_wren_o), 32'd0);
    chk("rst_sb7",   32'(busy_a_o), 32'd0);
    chk("rst_sb12",  32'(busy_b_o), 32'd0);
    v = '1;
    step();
    chk("rst_ptr", 32'(last_g), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(1, 0) == 1) begin
          v[i] = 1'b1; a[i] = AW'($urandom); d[i] = $urandom;
        end
      iv = ($urandom_range(1, 0) == 1);
      ia = AW'($urandom);
      if (m_sb[ia]) iv = 1'b0;
      ra = AW'($urandom);
      rb = a[$urandom_range(N - 1, 0)];
      r  = ($urandom_range(63, 0) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
